// File: rtl/game_pkg.sv
// Shared constants and state encoding for the game drawing path.
package game_pkg;

  localparam int SCR_W_DEFAULT = 160;
  localparam int SCR_H_DEFAULT = 120;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] CYAN  = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/plot_scheduler_rr_picker.sv
// Combinational round-robin picker: first set request bit searching upward
// from the slot after the last winner, wrapping around.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int LW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic            valid,
  output logic [NREQ-1:0] onehot
);

  always_comb begin
    int idx;
    idx    = 0;
    valid  = 1'b0;
    onehot = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!valid && req[idx]) begin
        valid       = 1'b1;
        onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/plot_scheduler.sv
// Round-robin arbiter that owns the vga_adapter plot port and scans each
// granted rectangle one pixel per clock, clipping to the visible screen.
module plot_scheduler
  import game_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int SCR_W = SCR_W_DEFAULT,
  parameter int SCR_H = SCR_H_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] rect_x,
  input  logic [NREQ*7-1:0] rect_y,
  input  logic [NREQ*8-1:0] rect_w,
  input  logic [NREQ*7-1:0] rect_h,
  input  logic [NREQ*3-1:0] rect_colour,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot
);

  localparam int LW = $clog2(NREQ);
  localparam logic [8:0] SCR_W_L = 9'(SCR_W);
  localparam logic [7:0] SCR_H_L = 8'(SCR_H);
  localparam logic [LW-1:0] LAST_RESET = LW'(NREQ - 1);

  state_t state_reg, state_next;

  logic [LW-1:0]   last_reg, last_next;
  logic [LW-1:0]   gidx_reg, gidx_next;
  logic [7:0]      x0_reg, w_reg;
  logic [6:0]      y0_reg, h_reg;
  logic [2:0]      col_reg;
  logic [7:0]      cx_reg, cx_next;
  logic [6:0]      cy_reg, cy_next;
  logic [NREQ-1:0] grant_reg, grant_next;
  logic [NREQ-1:0] done_reg, done_next;
  logic            busy_reg, busy_next;
  logic            plot_reg, plot_next;
  logic [7:0]      x_reg, x_next;
  logic [6:0]      y_reg, y_next;
  logic [2:0]      colour_reg, colour_next;
  logic            load;

  logic            pick_valid;
  logic [NREQ-1:0] pick_onehot;
  logic [LW-1:0]   pick_idx;

  logic [7:0] pcx;
  logic [6:0] pcy;
  logic [8:0] px;
  logic [7:0] py;
  logic       clip;
  logic       last_pixel;

  rr_picker #(.NREQ(NREQ), .LW(LW)) u_picker (
    .req    (req),
    .last   (last_reg),
    .valid  (pick_valid),
    .onehot (pick_onehot)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_onehot[i]) pick_idx = LW'(i);
    end
  end

  // Pixel to present next: origin on entry to SCAN, else the row-major successor.
  assign last_pixel = (cx_reg == w_reg - 8'd1) && (cy_reg == h_reg - 7'd1);

  always_comb begin
    pcx = '0;
    pcy = '0;
    if (state_reg == SCAN) begin
      if (cx_reg == w_reg - 8'd1) begin
        pcx = '0;
        pcy = cy_reg + 7'd1;
      end else begin
        pcx = cx_reg + 8'd1;
        pcy = cy_reg;
      end
    end
  end

  assign px   = {1'b0, x0_reg} + {1'b0, pcx};
  assign py   = {1'b0, y0_reg} + {1'b0, pcy};
  assign clip = (px >= SCR_W_L) || (py >= SCR_H_L);

  always_comb begin
    state_next  = state_reg;
    last_next   = last_reg;
    gidx_next   = gidx_reg;
    cx_next     = cx_reg;
    cy_next     = cy_reg;
    grant_next  = grant_reg;
    done_next   = '0;
    plot_next   = 1'b0;
    x_next      = x_reg;
    y_next      = y_reg;
    colour_next = colour_reg;
    load        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = LATCH;
          gidx_next  = pick_idx;
          grant_next = pick_onehot;
          load       = 1'b1;
        end
      end
      LATCH: begin
        cx_next = '0;
        cy_next = '0;
        if (w_reg == 8'd0 || h_reg == 7'd0) begin
          state_next = DONE;
          done_next  = grant_reg;
        end else begin
          state_next  = SCAN;
          plot_next   = !clip;
          x_next      = px[7:0];
          y_next      = py[6:0];
          colour_next = col_reg;
        end
      end
      SCAN: begin
        if (last_pixel) begin
          state_next = DONE;
          done_next  = grant_reg;
        end else begin
          cx_next   = pcx;
          cy_next   = pcy;
          plot_next = !clip;
          x_next    = px[7:0];
          y_next    = py[6:0];
        end
      end
      DONE: begin
        state_next = IDLE;
        grant_next = '0;
        last_next  = gidx_reg;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      last_reg   <= LAST_RESET;
      gidx_reg   <= '0;
      x0_reg     <= '0;
      y0_reg     <= '0;
      w_reg      <= '0;
      h_reg      <= '0;
      col_reg    <= '0;
      cx_reg     <= '0;
      cy_reg     <= '0;
      grant_reg  <= '0;
      done_reg   <= '0;
      busy_reg   <= 1'b0;
      plot_reg   <= 1'b0;
      x_reg      <= '0;
      y_reg      <= '0;
      colour_reg <= '0;
    end else begin
      state_reg  <= state_next;
      last_reg   <= last_next;
      gidx_reg   <= gidx_next;
      cx_reg     <= cx_next;
      cy_reg     <= cy_next;
      grant_reg  <= grant_next;
      done_reg   <= done_next;
      busy_reg   <= busy_next;
      plot_reg   <= plot_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      colour_reg <= colour_next;
      if (load) begin
        x0_reg  <= rect_x[pick_idx*8 +: 8];
        y0_reg  <= rect_y[pick_idx*7 +: 7];
        w_reg   <= rect_w[pick_idx*8 +: 8];
        h_reg   <= rect_h[pick_idx*7 +: 7];
        col_reg <= rect_colour[pick_idx*3 +: 3];
      end
    end
  end

  assign grant  = grant_reg;
  assign done   = done_reg;
  assign busy   = busy_reg;
  assign plot   = plot_reg;
  assign x      = x_reg;
  assign y      = y_reg;
  assign colour = colour_reg;

endmodule

// File: tb/tb_plot_scheduler.sv
// Directed self-checking bench for plot_scheduler; outputs sampled on negedge.
module tb_plot_scheduler;
  import game_pkg::*;

  localparam int NREQ = 4;

  logic              clk;
  logic              resetn;
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] rect_x;
  logic [NREQ*7-1:0] rect_y;
  logic [NREQ*8-1:0] rect_w;
  logic [NREQ*7-1:0] rect_h;
  logic [NREQ*3-1:0] rect_colour;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [7:0]        x;
  logic [6:0]        y;
  logic [2:0]        colour;
  logic              plot;

  int n_checks = 0;
  int n_fail   = 0;

  plot_scheduler #(.NREQ(NREQ), .SCR_W(160), .SCR_H(120)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req),
    .rect_x      (rect_x),
    .rect_y      (rect_y),
    .rect_w      (rect_w),
    .rect_h      (rect_h),
    .rect_colour (rect_colour),
    .grant       (grant),
    .done        (done),
    .busy        (busy),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_rect(input int i, input logic [7:0] rx, input logic [6:0] ry,
                          input logic [7:0] rw, input logic [6:0] rh, input logic [2:0] rc);
    rect_x[i*8 +: 8]      = rx;
    rect_y[i*7 +: 7]      = ry;
    rect_w[i*8 +: 8]      = rw;
    rect_h[i*7 +: 7]      = rh;
    rect_colour[i*3 +: 3] = rc;
  endtask

  task automatic do_reset();
    req    = '0;
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Observes one serve: grant rise, plot count, cycles from grant rise to done.
  task automatic run_serve(output logic [3:0] g, output logic [3:0] d,
                           output int nplot, output int lat, output bit to);
    int k;
    to = 1'b0; g = '0; d = '0; nplot = 0; lat = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (grant == '0 && k < 50);
    if (grant == '0) begin
      to = 1'b1;
      return;
    end
    g = grant;
    k = 0;
    while (done == '0 && k < 300) begin
      @(negedge clk);
      k++;
      if (plot) nplot++;
    end
    if (done == '0) to = 1'b1;
    d   = done;
    lat = k;
  endtask

  task automatic test_reset();
    req = '0;
    rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0; rect_colour = '0;
    resetn = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({grant, done, busy, plot, x, y, colour} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant=%b done=%b busy=%b plot=%b x=%0d y=%0d colour=%b, required all 0",
               grant, done, busy, plot, x, y, colour);
    end
    @(negedge clk);
    resetn = 1'b1;
    $display("test_reset: outputs checked");
  endtask

  task automatic test_single();
    do_reset();
    set_rect(0, 8'd74, 7'd10, 8'd13, 7'd1, GREEN);
    req = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0001 || plot !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latch: grant=%b plot=%b busy=%b, required 0001/0/1", grant, plot, busy);
    end
    req = '0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      n_checks++;
      if (plot !== 1'b1 || x !== 8'(74 + i) || y !== 7'd10 || colour !== GREEN || done !== '0) begin
        n_fail++;
        $display("FAIL single_pixel%0d: plot=%b x=%0d y=%0d colour=%b done=%b, required 1/%0d/10/010/0000",
                 i, plot, x, y, colour, done, 74 + i);
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 4'b0001 || plot !== 1'b0 || grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_done: done=%b plot=%b grant=%b, required 0001/0/0001", done, plot, grant);
    end
    @(negedge clk);
    n_checks++;
    if (done !== '0 || grant !== '0 || busy !== 1'b0 || colour !== GREEN) begin
      n_fail++;
      $display("FAIL single_idle: done=%b grant=%b busy=%b colour=%b, required 0000/0000/0/010",
               done, grant, busy, colour);
    end
    $display("test_single: 13-pixel row served");
  endtask

  task automatic test_two();
    logic [3:0] g, d;
    int np, lat;
    bit to;
    do_reset();
    set_rect(0, 8'd0, 7'd0, 8'd2, 7'd1, WHITE);
    set_rect(2, 8'd50, 7'd50, 8'd3, 7'd1, CYAN);
    req = 4'b0101;
    run_serve(g, d, np, lat, to);
    req[0] = 1'b0;
    n_checks++;
    if (to || g !== 4'b0001 || d !== 4'b0001 || np != 2 || lat != 3) begin
      n_fail++;
      $display("FAIL two_first: to=%0b grant=%b done=%b plots=%0d lat=%0d, required 0/0001/0001/2/3",
               to, g, d, np, lat);
    end
    @(negedge clk);
    n_checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL two_gap: grant=%b busy=%b, required 0000/0", grant, busy);
    end
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL two_second_grant: grant=%b, required 0100", grant);
    end
    req = '0;
    $display("test_two: req0 then req2 after idle gap");
  endtask

  task automatic test_back_to_back();
    logic [3:0] g, d;
    int np, lat;
    bit to;
    logic [3:0] order [6];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    do_reset();
    for (int i = 0; i < 4; i++) set_rect(i, 8'(10 * i), 7'(5 * i), 8'd2, 7'd2, WHITE);
    req = 4'b1111;
    for (int s = 0; s < 6; s++) begin
      run_serve(g, d, np, lat, to);
      n_checks++;
      if (to || g !== order[s] || d !== order[s] || np != 4 || lat != 5) begin
        n_fail++;
        $display("FAIL rr_serve%0d: to=%0b grant=%b done=%b plots=%0d lat=%0d, required 0/%b/%b/4/5",
                 s, to, g, d, np, lat, order[s], order[s]);
      end
      $display("test_back_to_back: serve %0d grant=%b", s, g);
    end
    req = '0;
  endtask

  task automatic test_empty();
    logic [3:0] g, d;
    int np, lat;
    bit to;
    do_reset();
    set_rect(1, 8'd20, 7'd20, 8'd0, 7'd5, WHITE);
    req = 4'b0010;
    run_serve(g, d, np, lat, to);
    req = '0;
    n_checks++;
    if (to || g !== 4'b0010 || d !== 4'b0010 || np != 0 || lat != 1) begin
      n_fail++;
      $display("FAIL empty_rect: to=%0b grant=%b done=%b plots=%0d lat=%0d, required 0/0010/0010/0/1",
               to, g, d, np, lat);
    end
    $display("test_empty: zero-width rect done without plots");
  endtask

  task automatic test_clip();
    int np;
    bit exp_plot;
    do_reset();
    set_rect(0, 8'd155, 7'd118, 8'd10, 7'd3, CYAN);
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    np = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      exp_plot = ((i % 10) < 5) && ((i / 10) < 2);
      if (plot) np++;
      n_checks++;
      if (plot !== exp_plot || x !== 8'(155 + i % 10) || y !== 7'(118 + i / 10)) begin
        n_fail++;
        $display("FAIL clip_cycle%0d: plot=%b x=%0d y=%0d, required %0b/%0d/%0d",
                 i, plot, x, y, exp_plot, 155 + i % 10, 118 + i / 10);
      end
    end
    @(negedge clk);
    n_checks++;
    if (np != 10 || done !== 4'b0001) begin
      n_fail++;
      $display("FAIL clip_total: plots=%0d done=%b, required 10/0001", np, done);
    end
    $display("test_clip: %0d plots in 30 scan cycles", np);
  endtask

  task automatic test_reset_midscan();
    logic [3:0] g, d;
    int np, lat, k;
    bit to;
    do_reset();
    set_rect(3, 8'd10, 7'd20, 8'd13, 7'd3, WHITE);
    set_rect(0, 8'd1, 7'd1, 8'd1, 7'd1, GREEN);
    req = 4'b1000;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (grant == '0 && k < 50);
    repeat (18) @(negedge clk);
    n_checks++;
    if (plot !== 1'b1 || y !== 7'd21 || x !== 8'd14) begin
      n_fail++;
      $display("FAIL midscan_plot: plot=%b x=%0d y=%0d, required 1/14/21", plot, x, y);
    end
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (plot !== 1'b0 || grant !== '0 || busy !== 1'b0 || done !== '0) begin
      n_fail++;
      $display("FAIL async_reset: plot=%b grant=%b busy=%b done=%b, required 0/0000/0/0000",
               plot, grant, busy, done);
    end
    @(negedge clk);
    resetn = 1'b1;
    req = 4'b1001;
    run_serve(g, d, np, lat, to);
    req = '0;
    n_checks++;
    if (to || g !== 4'b0001 || d !== 4'b0001 || np != 1) begin
      n_fail++;
      $display("FAIL post_reset_priority: to=%0b grant=%b done=%b plots=%0d, required 0/0001/0001/1",
               to, g, d, np);
    end
    $display("test_reset_midscan: scan aborted, requester 0 first after release");
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_back_to_back();
    test_empty();
    test_clip();
    test_reset_midscan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
